// File: rtl/przesuniecie_sekw_if.sv
// Request/response bundle of the sequential shift unit.
// Operands and mode travel towards the unit; the registered result and flags travel back.
interface przesuniecie_sekw_if #(
    parameter int BITS = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [BITS-1:0] i_arg_A;
    logic [BITS-1:0] i_arg_B;
    logic [1:0]      i_mode;
    logic            o_valid;
    logic [BITS-1:0] o_result;
    logic            o_error;
    logic            o_overflow;

    modport master (
        output i_valid,
        output i_arg_A,
        output i_arg_B,
        output i_mode,
        input  o_ready,
        input  o_valid,
        input  o_result,
        input  o_error,
        input  o_overflow
    );

    modport slave (
        input  i_valid,
        input  i_arg_A,
        input  i_arg_B,
        input  i_mode,
        output o_ready,
        output o_valid,
        output o_result,
        output o_error,
        output o_overflow
    );
endinterface

// File: rtl/przesuniecie_sekw.sv
// Iterative shifter/rotator: moves the operand STEP bits per clock (LSR, ASR, LSL, ROR)
// behind a valid/ready handshake, with a registered result and error/overflow flags.
module przesuniecie_sekw #(
    parameter int BITS     = 32,
    parameter int STEP     = 1,
    parameter int INVERT_B = 1
) (
    input logic                i_clk,
    input logic                i_rst_n,
    przesuniecie_sekw_if.slave bus
);
    localparam int              CW       = $clog2(BITS + 1);
    localparam logic [BITS-1:0] BITS_V   = BITS'(BITS);
    localparam logic [CW-1:0]   BITS_C   = CW'(BITS);
    localparam logic [CW-1:0]   STEP_C   = CW'(STEP);
    localparam logic [1:0]      MODE_LSR = 2'b00;
    localparam logic [1:0]      MODE_ASR = 2'b01;
    localparam logic [1:0]      MODE_LSL = 2'b10;
    localparam logic [1:0]      MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [BITS-1:0] work;
    logic [CW-1:0]   remaining;
    logic [1:0]      mode_q;
    logic            sign_q;
    logic [BITS-1:0] result_q;
    logic            error_q;
    logic            overflow_q;

    logic [BITS-1:0] amt;
    logic [BITS-1:0] amt_n;
    logic            amt_neg;
    logic            amt_big;
    logic            amt_zero;
    logic            accept;
    logic            direct;
    logic            last_step;
    logic [CW-1:0]   step_amt;
    logic [BITS-1:0] fill;
    logic [BITS-1:0] shifted;

    // Amount decode; only meaningful on the accepting edge.
    always_comb begin
        amt      = (INVERT_B != 0) ? ~bus.i_arg_B : bus.i_arg_B;
        amt_neg  = amt[BITS-1];
        amt_big  = (bus.i_mode != MODE_ROR) && (amt > BITS_V);
        amt_n    = (bus.i_mode == MODE_ROR) ? (amt % BITS_V) : amt;
        amt_zero = (amt_n == '0);
    end

    // One iteration of the working register; the final iteration may be shorter than STEP.
    always_comb begin
        step_amt = (remaining > STEP_C) ? STEP_C : remaining;
        fill     = sign_q ? ~({BITS{1'b1}} >> step_amt) : '0;
        shifted  = work;
        case (mode_q)
            MODE_LSR: shifted = work >> step_amt;
            MODE_ASR: shifted = (work >> step_amt) | fill;
            MODE_LSL: shifted = work << step_amt;
            MODE_ROR: shifted = (work >> step_amt) | (work << (BITS_C - step_amt));
            default:  shifted = work;
        endcase
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        direct     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    accept     = 1'b1;
                    direct     = amt_neg || amt_big || amt_zero;
                    next_state = direct ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                last_step = (remaining == step_amt);
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work      <= '0;
            remaining <= '0;
            mode_q    <= MODE_LSR;
            sign_q    <= 1'b0;
        end else if (accept) begin
            work      <= bus.i_arg_A;
            remaining <= CW'(amt_n);
            mode_q    <= bus.i_mode;
            sign_q    <= bus.i_arg_A[BITS-1];
        end else if (state == SHIFT) begin
            work      <= shifted;
            remaining <= remaining - step_amt;
        end
    end

    // Outputs load only on the edge that enters DONE, so they hold between results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q   <= '0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept && direct) begin
            result_q   <= (amt_neg || amt_big) ? '0 : bus.i_arg_A;
            error_q    <= amt_neg;
            overflow_q <= !amt_neg && amt_big;
        end else if (last_step) begin
            result_q   <= shifted;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end
    end

    assign bus.o_ready    = (state == IDLE) && i_rst_n;
    assign bus.o_valid    = (state == DONE);
    assign bus.o_result   = result_q;
    assign bus.o_error    = error_q;
    assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_przesuniecie_sekw.sv
// Bench for przesuniecie_sekw: a STEP=1 and a STEP=4 instance checked against a plain-arithmetic
// reference model, covering directed corner vectors, random operations, throughput, ignore and abort.
module tb_przesuniecie_sekw;
    localparam int BITS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    przesuniecie_sekw_if #(.BITS(BITS)) bus1 ();
    przesuniecie_sekw_if #(.BITS(BITS)) bus4 ();

    przesuniecie_sekw #(.BITS(BITS), .STEP(1), .INVERT_B(1)) dut1 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus1)
    );

    przesuniecie_sekw #(.BITS(BITS), .STEP(4), .INVERT_B(1)) dut4 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus4)
    );

    typedef struct {
        bit          use4;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        logic [31:0] r;
        logic        e;
        logic        o;
        int          lat;
    } vec_t;

    // Reference: amount = ~B as signed; result from whole-word arithmetic on widened operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                  input int step, output logic [31:0] r, output logic e,
                                  output logic o, output int lat);
        logic signed [31:0] amt;
        logic [63:0]        w;
        int                 n;
        amt = ~b;
        r = '0; e = 1'b0; o = 1'b0; lat = 1;
        if (amt < 0) begin
            e = 1'b1;
        end else if (m != 2'd3 && amt > 32) begin
            o = 1'b1;
        end else begin
            n = (m == 2'd3) ? (int'(amt) % 32) : int'(amt);
            case (m)
                2'd0:    w = {32'h0, a} >> n;
                2'd1:    w = {{32{a[31]}}, a} >> n;
                2'd2:    w = {32'h0, a} << n;
                default: w = {a, a} >> n;
            endcase
            r   = w[31:0];
            lat = (n == 0) ? 1 : ((n + step - 1) / step) + 1;
        end
    endfunction

    task automatic drive_req(input bit use4, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] m);
        if (use4) begin
            bus4.i_valid = v; bus4.i_arg_A = a; bus4.i_arg_B = b; bus4.i_mode = m;
        end else begin
            bus1.i_valid = v; bus1.i_arg_A = a; bus1.i_arg_B = b; bus1.i_mode = m;
        end
    endtask

    // Issues one request and observes the response; returns observations only.
    task automatic run_op(input bit use4, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, output int lat, output logic [31:0] res,
                          output logic err, output logic ovf, output bit busy_ok,
                          output bit held_ok, output bit single_ok);
        logic [31:0] prev;
        int          wait_cnt;
        lat = -1; res = '0; err = 1'b0; ovf = 1'b0;
        busy_ok = 1'b1; held_ok = 1'b1; single_ok = 1'b1;
        wait_cnt = 0;
        while (!(use4 ? bus4.o_ready : bus1.o_ready) && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        prev = use4 ? bus4.o_result : bus1.o_result;
        drive_req(use4, 1'b1, a, b, m);
        @(posedge clk); #1;
        drive_req(use4, 1'b0, $urandom, $urandom, 2'($urandom));
        for (int c = 1; c <= 100; c++) begin
            if (use4 ? bus4.o_ready : bus1.o_ready) busy_ok = 1'b0;
            if (use4 ? bus4.o_valid : bus1.o_valid) begin
                lat = c;
                res = use4 ? bus4.o_result : bus1.o_result;
                err = use4 ? bus4.o_error : bus1.o_error;
                ovf = use4 ? bus4.o_overflow : bus1.o_overflow;
                break;
            end
            if ((use4 ? bus4.o_result : bus1.o_result) !== prev) held_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (use4 ? bus4.o_valid : bus1.o_valid) single_ok = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({bus1.o_ready, bus1.o_valid, bus1.o_error, bus1.o_overflow} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got ready/valid/err/ovf=%b required 0000",
                     {bus1.o_ready, bus1.o_valid, bus1.o_error, bus1.o_overflow});
        end
        checks++;
        if (bus1.o_result !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %h required 00000000", bus1.o_result);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus1.o_ready, bus4.o_ready} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: got %b required 11", {bus1.o_ready, bus4.o_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t        v[10];
        int          lat;
        logic [31:0] res;
        logic        err, ovf;
        bit          busy_ok, held_ok, single_ok;
        v[0] = '{1'b0, 32'hF000_0000, 32'hFFFF_FFFB, 2'd0, 32'h0F00_0000, 1'b0, 1'b0, 5};
        v[1] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFDF, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        v[2] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFDF, 2'd2, 32'h0000_0000, 1'b0, 1'b0, 33};
        v[3] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b1, 1'b0, 1};
        v[4] = '{1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFD7, 2'd2, 32'h0000_0000, 1'b0, 1'b1, 1};
        v[5] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFD7, 2'd3, 32'h0100_0000, 1'b0, 1'b0, 9};
        v[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2'd0, 32'h03FF_FFFF, 1'b0, 1'b0, 3};
        v[7] = '{1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFDF, 2'd1, 32'h0000_0000, 1'b0, 1'b0, 33};
        v[8] = '{1'b0, 32'h1234_5678, 32'hFFFF_FFDF, 2'd3, 32'h1234_5678, 1'b0, 1'b0, 1};
        v[9] = '{1'b0, 32'hABCD_0000, 32'hFFFF_FFFF, 2'd0, 32'hABCD_0000, 1'b0, 1'b0, 1};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].use4, v[i].a, v[i].b, v[i].m, lat, res, err, ovf, busy_ok, held_ok, single_ok);
            checks++;
            if ({res, err, ovf} !== {v[i].r, v[i].e, v[i].o}) begin
                failures++;
                $display("[TB] FAIL directed_%0d_result: got %h e=%b o=%b required %h e=%b o=%b",
                         i, res, err, ovf, v[i].r, v[i].e, v[i].o);
            end
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("[TB] FAIL directed_%0d_latency: got %0d required %0d", i, lat, v[i].lat);
            end
            checks++;
            if ({busy_ok, held_ok, single_ok} !== 3'b111) begin
                failures++;
                $display("[TB] FAIL directed_%0d_busy_hold_pulse: got %b required 111",
                         i, {busy_ok, held_ok, single_ok});
            end
        end
    endtask

    task automatic run_random(input bit use4, input int count, input string tag);
        int                 lat, exp_lat, cat;
        logic [31:0]        a, b, res, exp_r;
        logic [1:0]         m;
        logic               err, ovf, exp_e, exp_o;
        logic signed [31:0] amt;
        bit                 busy_ok, held_ok, single_ok;
        for (int i = 0; i < count; i++) begin
            a   = $urandom;
            m   = 2'($urandom);
            cat = $urandom_range(0, 9);
            case (cat)
                0:       amt = {1'b1, 31'($urandom)};
                1:       amt = 32'($urandom_range(33, 100));
                2:       amt = {1'b0, 31'($urandom)};
                default: amt = 32'($urandom_range(0, 32));
            endcase
            b = ~amt;
            model(a, b, m, use4 ? 4 : 1, exp_r, exp_e, exp_o, exp_lat);
            run_op(use4, a, b, m, lat, res, err, ovf, busy_ok, held_ok, single_ok);
            checks++;
            if ({res, err, ovf, lat} !== {exp_r, exp_e, exp_o, exp_lat} ||
                {busy_ok, held_ok, single_ok} !== 3'b111) begin
                failures++;
                $display("[TB] FAIL %s_%0d: A=%h B=%h mode=%0d got %h e=%b o=%b lat=%0d flags=%b required %h e=%b o=%b lat=%0d flags=111",
                         tag, i, a, b, m, res, err, ovf, lat, {busy_ok, held_ok, single_ok},
                         exp_r, exp_e, exp_o, exp_lat);
            end
        end
    endtask

    task automatic test_random();
        run_random(1'b0, 40, "random_step1");
    endtask

    task automatic test_step4();
        run_random(1'b1, 25, "random_step4");
    endtask

    task automatic test_back_to_back();
        int          pulses[$];
        logic [31:0] results[$];
        drive_req(1'b0, 1'b1, 32'h00F0_0F00, ~32'd4, 2'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus1.o_valid) begin
                pulses.push_back(c);
                results.push_back(bus1.o_result);
            end
            @(posedge clk); #1;
        end
        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (pulses.size() < 2) begin
            failures++;
            $display("[TB] FAIL b2b_pulses: got %0d pulses required at least 2", pulses.size());
        end else if (pulses[1] - pulses[0] !== 6) begin
            failures++;
            $display("[TB] FAIL b2b_period: got %0d cycles required 6", pulses[1] - pulses[0]);
        end
        checks++;
        if (results.size() < 2 || results[0] !== 32'h000F_00F0 || results[1] !== 32'h000F_00F0) begin
            failures++;
            $display("[TB] FAIL b2b_result: got %0d results first %h required 2 x 000f00f0",
                     results.size(), (results.size() > 0) ? results[0] : 32'h0);
        end
    endtask

    task automatic test_ignore();
        int          lat, extra;
        logic [31:0] res;
        lat = -1; res = '0; extra = 0;
        drive_req(1'b0, 1'b1, 32'hC000_1234, ~32'd10, 2'd0);
        @(posedge clk); #1;
        for (int c = 1; c <= 60; c++) begin
            if (c == 2) drive_req(1'b0, 1'b1, 32'h1234_5678, ~32'd1, 2'd3);
            else        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
            if (bus1.o_valid) begin
                lat = c;
                res = bus1.o_result;
                break;
            end
            @(posedge clk); #1;
        end
        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus1.o_valid) extra++;
        end
        checks++;
        if ({res, lat} !== {32'h0030_0004, 11}) begin
            failures++;
            $display("[TB] FAIL ignore_result: got %h lat=%0d required 00300004 lat=11", res, lat);
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("[TB] FAIL ignore_not_queued: got %0d extra pulses required 0", extra);
        end
    endtask

    task automatic test_abort();
        int          lat, spurious;
        logic [31:0] res;
        logic        err, ovf;
        bit          busy_ok, held_ok, single_ok;
        run_op(1'b0, 32'h0000_0001, ~32'd8, 2'd3, lat, res, err, ovf, busy_ok, held_ok, single_ok);
        checks++;
        if (res !== 32'h0100_0000) begin
            failures++;
            $display("[TB] FAIL abort_setup: got %h required 01000000", res);
        end
        spurious = 0;
        drive_req(1'b0, 1'b1, 32'hFFFF_0000, ~32'd10, 2'd0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'h5555_5555, ~32'd2, 2'd2);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.o_result, bus1.o_error, bus1.o_overflow, bus1.o_valid, bus1.o_ready} !== 36'h0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got result=%h e=%b o=%b v=%b r=%b required all 0",
                     bus1.o_result, bus1.o_error, bus1.o_overflow, bus1.o_valid, bus1.o_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus1.o_valid) spurious++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus1.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_ready_after: got %b required 1", bus1.o_ready);
        end
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus1.o_valid) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_valid: got %0d pulses required 0", spurious);
        end
        run_op(1'b0, 32'h0000_0003, ~32'd2, 2'd2, lat, res, err, ovf, busy_ok, held_ok, single_ok);
        checks++;
        if ({res, err, ovf, lat} !== {32'h0000_000C, 1'b0, 1'b0, 3}) begin
            failures++;
            $display("[TB] FAIL abort_recover: got %h e=%b o=%b lat=%0d required 0000000c e=0 o=0 lat=3",
                     res, err, ovf, lat);
        end
    endtask

    initial begin
        drive_req(1'b0, 1'b0, '0, '0, 2'd0);
        drive_req(1'b1, 1'b0, '0, '0, 2'd0);
        test_reset();
        test_directed();
        test_random();
        test_step4();
        test_back_to_back();
        test_ignore();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end
endmodule
